// File: rtl/instr_rom_loadable.sv
// ----------------------------------------------------------------------------
// instr_rom_loadable
//
// Synchronous-read instruction memory for the MIPS core. After reset the
// array is cleared in hardware, one word per cycle. The memory then enters
// LOAD, where a boot loader writes words through the program port, or RUN,
// where the fetch port serves instruction reads.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   fetch_req    fetch request
//   fetch_addr   fetch byte address (ADDR_W bits)
//   fetch_ready  a fetch request is accepted this cycle (RUN only)
//   rdata_valid  rdata/fetch_err carry a response this cycle
//   rdata        fetched instruction word (0 on a faulting fetch)
//   fetch_err    the response belongs to a misaligned or out-of-range fetch
//   prog_en      request LOAD mode (sampled at the end of CLEAR and in RUN)
//   prog_we      program-port write strobe (LOAD only)
//   prog_addr    program word index
//   prog_wdata   program word
//   prog_done    loading finished, go to RUN
//   busy         high while the clear sequence runs
//   state        current state: CLEAR=0, LOAD=1, RUN=2
// ----------------------------------------------------------------------------
module instr_rom_loadable #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 31,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              fetch_err,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  input  logic              prog_done,
  output logic              busy,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Last index written by the clear sequence.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // First byte address past the array. One bit wider than fetch_addr so the
  // full address is compared: high addresses never alias onto low words.
  localparam logic [ADDR_W:0] FETCH_LIMIT = (ADDR_W + 1)'(4 * DEPTH);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              prog_in_range;
  logic              accept;
  logic              addr_legal;
  logic [IDX_W-1:0]  fetch_idx;

  // --------------------------------------------------------------------------
  // Program-port range check. When DEPTH fills the index space every
  // prog_addr is in range, and comparing would only yield a constant.
  // --------------------------------------------------------------------------
  generate
    if (DEPTH == (1 << IDX_W)) begin : g_prog_full
      assign prog_in_range = 1'b1;
    end else begin : g_prog_partial
      localparam logic [IDX_W:0] PROG_LIMIT = (IDX_W + 1)'(DEPTH);
      assign prog_in_range = ({1'b0, prog_addr} < PROG_LIMIT);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Fetch decode
  // --------------------------------------------------------------------------
  assign accept     = fetch_req && fetch_ready;
  assign addr_legal = ({1'b0, fetch_addr} < FETCH_LIMIT) && (fetch_addr[1:0] == 2'b00);
  assign fetch_idx  = fetch_addr[IDX_W+1:2];

  // --------------------------------------------------------------------------
  // State register and clear counter
  // --------------------------------------------------------------------------
  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples values from before the edge, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // The counter wraps to 0 after LAST_IDX, ready for the next clear.
      if (state_q == ST_CLEAR) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state, status outputs and write-port selection
  // --------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    fetch_ready = 1'b0;
    busy        = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = cnt_q;
    mem_wdata   = '0;

    case (state_q)
      ST_CLEAR: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = prog_en ? ST_LOAD : ST_RUN;
        end
      end

      ST_LOAD: begin
        // A write in the same cycle as prog_done still commits.
        if (prog_we && prog_in_range) begin
          mem_we    = 1'b1;
          mem_waddr = prog_addr;
          mem_wdata = prog_wdata;
        end
        if (prog_done) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        fetch_ready = 1'b1;
        if (prog_en) begin
          state_d = ST_LOAD;
        end
      end

      default: begin
        // Unused encoding: restart through a full clear.
        state_d = ST_CLEAR;
      end
    endcase
  end

  assign state = state_q;

  // --------------------------------------------------------------------------
  // Memory write port
  // --------------------------------------------------------------------------
  // NOTE: the array has no reset branch; resetting it would turn it into
  // DEPTH*DATA_W discrete flops. The clear sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Registered fetch response
  // --------------------------------------------------------------------------
  // Fetches are only accepted in RUN, where no write can occur, so the read
  // never collides with a write to the same word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_valid <= 1'b0;
      rdata       <= '0;
      fetch_err   <= 1'b0;
    end else begin
      rdata_valid <= accept;
      fetch_err   <= accept && !addr_legal;
      if (accept) begin
        rdata <= addr_legal ? mem[fetch_idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_instr_rom_loadable.sv
// ----------------------------------------------------------------------------
// tb_instr_rom_loadable
//
// Directed self-checking bench for instr_rom_loadable (DEPTH=256). Inputs
// change 1 ns after a rising edge; outputs are sampled at the same point,
// after the edge has settled and before new stimulus is applied.
// ----------------------------------------------------------------------------
module tb_instr_rom_loadable;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 31;
  localparam int IDX_W  = 8;

  logic              clk;
  logic              reset;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              fetch_err;
  logic              prog_en;
  logic              prog_we;
  logic [IDX_W-1:0]  prog_addr;
  logic [DATA_W-1:0] prog_wdata;
  logic              prog_done;
  logic              busy;
  logic [1:0]        state;

  int n_checks = 0;
  int n_passed = 0;

  instr_rom_loadable #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .fetch_err   (fetch_err),
    .prog_en     (prog_en),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_wdata  (prog_wdata),
    .prog_done   (prog_done),
    .busy        (busy),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_passed++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle synchronous reset; checks the reset values right after it.
  task automatic do_reset(input logic pen);
    reset   = 1'b1;
    prog_en = pen;
    tick();
    reset = 1'b0;
    check("rst_state",       32'(state),       32'd0);
    check("rst_busy",        32'(busy),        32'd1);
    check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
    check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    check("rst_rdata",       rdata,            32'h0);
    check("rst_fetch_err",   32'(fetch_err),   32'd0);
  endtask

  // Counts the cycles busy stays high (reset edge included), bounded, and
  // checks that no fetch is offered or answered while clearing.
  task automatic wait_clear(input logic [1:0] exp_state);
    int n   = 0;
    int bad = 0;
    while (busy && n < 400) begin
      if (rdata_valid || fetch_ready) bad++;
      n++;
      tick();
    end
    check("clear_cycles",    32'(n),     32'd256);
    check("clear_no_fetch",  32'(bad),   32'd0);
    check("clear_end_state", 32'(state), 32'(exp_state));
  endtask

  task automatic prog_write(input logic [IDX_W-1:0] idx, input logic [31:0] data,
                            input logic done);
    prog_we    = 1'b1;
    prog_addr  = idx;
    prog_wdata = data;
    prog_done  = done;
    tick();
    prog_we   = 1'b0;
    prog_done = 1'b0;
  endtask

  // Single fetch: response must appear right after the accepting edge and
  // be gone one cycle later with fetch_err cleared.
  task automatic fetch(input string tag, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] exp_data, input logic exp_err);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    tick();
    fetch_req = 1'b0;
    check({tag, "_valid"}, 32'(rdata_valid), 32'd1);
    check({tag, "_rdata"}, rdata,            exp_data);
    check({tag, "_err"},   32'(fetch_err),   32'(exp_err));
    tick();
    check({tag, "_idle_valid"}, 32'(rdata_valid), 32'd0);
    check({tag, "_idle_err"},   32'(fetch_err),   32'd0);
  endtask

  initial begin
    logic [ADDR_W-1:0] b2b_addr [3];
    logic [31:0]       b2b_data [3];

    reset      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    prog_en    = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
    prog_done  = 1'b0;
    repeat (2) tick();

    // Clear straight into RUN; freshly cleared memory reads as zero.
    do_reset(1'b0);
    wait_clear(2'd2);
    check("run_fetch_ready", 32'(fetch_ready), 32'd1);
    fetch("clr_f10", 31'h10, 32'h0, 1'b0);

    // Clear into LOAD, program three words (last one alongside prog_done).
    do_reset(1'b1);
    wait_clear(2'd1);
    prog_en = 1'b0;
    check("load_fetch_ready", 32'(fetch_ready), 32'd0);
    check("load_busy",        32'(busy),        32'd0);
    prog_write(8'd0,  32'h20040054, 1'b0);
    prog_write(8'd1,  32'h2005000c, 1'b0);
    prog_write(8'd12, 32'h1485fff8, 1'b1);
    check("load_to_run", 32'(state), 32'd2);
    fetch("ld_f04", 31'h4,  32'h2005000c, 1'b0);
    fetch("ld_f30", 31'h30, 32'h1485fff8, 1'b0);

    // Back-to-back fetches: one response per cycle.
    b2b_addr[0] = 31'h0; b2b_data[0] = 32'h20040054;
    b2b_addr[1] = 31'h4; b2b_data[1] = 32'h2005000c;
    b2b_addr[2] = 31'h8; b2b_data[2] = 32'h00000000;
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = b2b_addr[i];
      tick();
      check($sformatf("b2b%0d_valid", i), 32'(rdata_valid), 32'd1);
      check($sformatf("b2b%0d_rdata", i), rdata,            b2b_data[i]);
      check($sformatf("b2b%0d_err", i),   32'(fetch_err),   32'd0);
    end
    fetch_req = 1'b0;
    tick();
    check("b2b_idle_valid", 32'(rdata_valid), 32'd0);

    // Address faults and the last legal word.
    fetch("err_400",      31'h400,      32'h0, 1'b1);
    fetch("err_7ffffffc", 31'h7ffffffc, 32'h0, 1'b1);
    fetch("err_002",      31'h2,        32'h0, 1'b1);
    fetch("edge_3fc",     31'h3fc,      32'h0, 1'b0);
    fetch("after_err_00", 31'h0,        32'h20040054, 1'b0);

    // RUN -> LOAD while a fetch is accepted in the same cycle.
    fetch_req  = 1'b1;
    fetch_addr = 31'h0;
    prog_en    = 1'b1;
    tick();
    fetch_req = 1'b0;
    prog_en   = 1'b0;
    check("sw_valid",       32'(rdata_valid), 32'd1);
    check("sw_rdata",       rdata,            32'h20040054);
    check("sw_state",       32'(state),       32'd1);
    check("sw_fetch_ready", 32'(fetch_ready), 32'd0);
    prog_write(8'd2, 32'h12345678, 1'b0);
    prog_write(8'd3, 32'hcafef00d, 1'b1);
    fetch("sw_f08", 31'h8, 32'h12345678, 1'b0);
    fetch("sw_f0c", 31'hc, 32'hcafef00d, 1'b0);

    // Reset in LOAD after a write; the clear wipes it. Fetch and program
    // inputs are held active through CLEAR and must have no effect.
    prog_en = 1'b1;
    tick();
    prog_en = 1'b0;
    check("rl_state", 32'(state), 32'd1);
    prog_write(8'd0, 32'hdeadbeef, 1'b0);
    fetch_req  = 1'b1;
    fetch_addr = 31'h0;
    do_reset(1'b0);
    prog_we    = 1'b1;
    prog_addr  = 8'd4;
    prog_wdata = 32'hffffffff;
    wait_clear(2'd2);
    fetch_req = 1'b0;
    prog_we   = 1'b0;
    tick();
    fetch("rl_f00", 31'h0,  32'h0, 1'b0);
    fetch("rl_f08", 31'h8,  32'h0, 1'b0);
    fetch("rl_f10", 31'h10, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
